// File: rtl/dl_pkg.sv
// Shared constants and types for the HPS download sequencer: ioctl index map,
// game-select values and the sequencer state set.
package dl_pkg;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    typedef enum logic [7:0] {
        MOD_BWIDOW   = 8'd0,
        MOD_GRAVITAR = 8'd1,
        MOD_LUNARBAT = 8'd2,
        MOD_SPACDUEL = 8'd3
    } mod_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_ROM,
        HOLD,
        RUN
    } state_e;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module hold_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/dl_sequencer.sv
// Routes HPS ioctl downloads to the ROM write port, mod byte and DIP bank,
// and holds the core in reset through a ROM load plus a fixed settle delay.
module dl_sequencer
    import dl_pkg::*;
#(
    parameter int ROM_BYTES   = 65536,
    parameter int HOLD_CYCLES = 1024,
    parameter int DIP_COUNT   = 8
) (
    input  logic                   clk_25,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic                   dn_wr,
    output logic [15:0]            dn_addr,
    output logic [7:0]             dn_data,
    output logic [7:0]             mod,
    output logic [8*DIP_COUNT-1:0] dips,
    output logic                   core_hold,
    output logic                   rom_loaded,
    output logic                   rom_err,
    output logic [16:0]            byte_count
);

    localparam int          DIP_AW     = (DIP_COUNT > 1) ? $clog2(DIP_COUNT) : 1;
    localparam int          TIMER_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [24:0] ROM_LIMIT  = 25'(ROM_BYTES);
    localparam logic [24:0] DIP_LIMIT  = 25'(DIP_COUNT);
    localparam logic [16:0] COUNT_FULL = 17'(ROM_BYTES);
    localparam logic [16:0] COUNT_MAX  = '1;

    state_e        state_q, state_d;
    logic [16:0]   byte_count_q, byte_count_d;
    logic          rom_err_q, rom_err_d;
    logic          rom_loaded_q, rom_loaded_d;
    logic          core_hold_q;
    logic          dn_wr_q;
    logic [15:0]   dn_addr_q;
    logic [7:0]    dn_data_q;
    logic [7:0]    mod_q;
    logic [7:0]    dips_q [DIP_COUNT];

    logic          rom_start, rom_wr, rom_ok, rom_bad, restart;
    logic          mod_wr, dip_wr;
    logic [16:0]   count_inc;
    logic          timer_load, timer_en, timer_done;

    assign rom_start = ioctl_download && (ioctl_index == IDX_ROM);
    assign restart   = rom_start && (state_q != LOAD_ROM);
    assign rom_wr    = (state_q == LOAD_ROM) && ioctl_wr && (ioctl_index == IDX_ROM);
    assign rom_ok    = rom_wr && (ioctl_addr < ROM_LIMIT);
    assign rom_bad   = rom_wr && !(ioctl_addr < ROM_LIMIT);
    assign count_inc = (byte_count_q == COUNT_MAX) ? byte_count_q : byte_count_q + 1'b1;
    assign mod_wr    = ioctl_wr && (ioctl_index == IDX_MOD) && (ioctl_addr == '0);
    assign dip_wr    = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr < DIP_LIMIT);

    always_comb begin
        state_d      = state_q;
        byte_count_d = byte_count_q;
        rom_err_d    = rom_err_q;
        rom_loaded_d = rom_loaded_q;
        timer_load   = 1'b0;
        timer_en     = 1'b0;
        if (restart) begin
            state_d      = LOAD_ROM;
            byte_count_d = '0;
            rom_err_d    = 1'b0;
            rom_loaded_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_ROM: begin
                    if (rom_ok) begin
                        byte_count_d = count_inc;
                    end
                    if (rom_bad) begin
                        rom_err_d = 1'b1;
                    end
                    // A byte arriving with the falling edge is counted before the size check.
                    if (!ioctl_download) begin
                        state_d    = HOLD;
                        timer_load = 1'b1;
                        if (byte_count_d != COUNT_FULL) begin
                            rom_err_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (timer_done) begin
                        state_d      = RUN;
                        rom_loaded_d = !rom_err_q;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_count_q <= '0;
            rom_err_q    <= 1'b0;
            rom_loaded_q <= 1'b0;
            core_hold_q  <= 1'b1;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            mod_q        <= MOD_BWIDOW;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            rom_err_q    <= rom_err_d;
            rom_loaded_q <= rom_loaded_d;
            core_hold_q  <= (state_d != RUN);
            dn_wr_q      <= rom_ok;
            if (rom_ok) begin
                dn_addr_q <= ioctl_addr[15:0];
                dn_data_q <= ioctl_dout;
            end
            if (mod_wr) begin
                mod_q <= ioctl_dout;
            end
        end
    end

    for (genvar gi = 0; gi < DIP_COUNT; gi++) begin : g_dip
        always_ff @(posedge clk_25 or posedge reset) begin
            if (reset) begin
                dips_q[gi] <= '0;
            end else if (dip_wr && ioctl_addr[DIP_AW-1:0] == DIP_AW'(gi)) begin
                dips_q[gi] <= ioctl_dout;
            end
        end
        assign dips[8*gi +: 8] = dips_q[gi];
    end

    hold_timer #(
        .WIDTH(TIMER_W)
    ) u_hold_timer (
        .clk_i      (clk_25),
        .rst_i      (reset),
        .load_i     (timer_load),
        .load_val_i (TIMER_W'(HOLD_CYCLES - 1)),
        .en_i       (timer_en),
        .done_o     (timer_done)
    );

    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign mod        = mod_q;
    assign core_hold  = core_hold_q;
    assign rom_loaded = rom_loaded_q;
    assign rom_err    = rom_err_q;
    assign byte_count = byte_count_q;

endmodule

// File: doc/dl_sequencer.md
Name: dl_sequencer

Overview:
- Sequences HPS ioctl downloads into the arcade core on the clk_25 domain; sole owner of the core's ROM write port, the mod byte and the DIP bank.
- Routes each ioctl byte by index: ROM image (index 0), game-select mod byte (index 1), DIP bytes (index 254).
- Holds the core in reset for the whole ROM load plus a fixed post-load delay, then releases it.
- Reports load status and errors.

Parameters:
- ROM_BYTES, 65536, ROM image size in bytes; valid ROM addresses are 0..ROM_BYTES-1.
- HOLD_CYCLES, 1024, number of clk_25 cycles core_hold stays high after ROM download ends.
- DIP_COUNT, 8, number of DIP bytes accepted; index 254 addresses 0..DIP_COUNT-1.

Ports:
- clk_25  in  1  system clock; all logic runs on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  HPS download-active flag.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_index  in  8  download index.
- ioctl_addr  in  25  byte address within the current download.
- ioctl_dout  in  8  byte data.
- dn_wr  out  1  registered ROM write strobe to the core.
- dn_addr  out  16  registered ROM write address.
- dn_data  out  8  registered ROM write data.
- mod  out  8  game-select byte: 0 = bwidow, 1 = gravitar, 2 = lunarbat, 3 = spacduel.
- dips  out  8*DIP_COUNT  DIP bank, flattened; byte k is dips[8k+7:8k].
- core_hold  out  1  active-high core reset request; ORed with the user reset at top level.
- rom_loaded  out  1  set after a complete, error-free ROM download.
- rom_err  out  1  sticky error flag for the last ROM download.
- byte_count  out  17  number of ROM bytes accepted in the current or last ROM download.

Behaviour:
- Reset values: dn_wr=0, dn_addr=0, dn_data=0, mod=0, dips=all 0, core_hold=1, rom_loaded=0, rom_err=0, byte_count=0, state=IDLE.
- All outputs are registered.
- States and transitions:
  - IDLE: core_hold=1.
    - ioctl_download & index 0 -> LOAD_ROM; clears byte_count, rom_err and rom_loaded on entry.
    - Index 1 or 254 downloads are handled in IDLE without a state change.
  - LOAD_ROM: core_hold=1.
    - ioctl_wr with ioctl_addr < ROM_BYTES: dn_wr=1 on the next cycle, with dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout; byte_count increments. Latency is exactly 1 cycle.
    - ioctl_wr with ioctl_addr >= ROM_BYTES: byte dropped, no dn_wr, rom_err set.
    - Falling edge of ioctl_download -> HOLD; the hold counter loads HOLD_CYCLES-1.
    - rom_err is also set at exit if byte_count != ROM_BYTES.
  - HOLD: core_hold=1; the counter decrements each cycle.
    - Counter at 0 -> RUN; rom_loaded = !rom_err, set on the same edge that drops core_hold.
    - A new index-0 download -> LOAD_ROM immediately and restarts the sequence.
  - RUN: core_hold=0.
    - A new index-0 download -> LOAD_ROM; core_hold rises on the next cycle and rom_loaded clears.
- Index 1 (mod):
  - Accepted in any state; only ioctl_addr==0 is stored; mod updates 1 cycle after ioctl_wr.
  - core_hold is unaffected.
  - Bytes at nonzero addresses are ignored.
- Index 254 (DIP):
  - Bytes with ioctl_addr < DIP_COUNT write dips byte ioctl_addr[2:0], 1 cycle after ioctl_wr.
  - Higher addresses are ignored; accepted in any state.
- Any other index: ignored, no state change, no output change.
- dn_wr is a single-cycle pulse per accepted byte.
- Back-to-back ioctl_wr on consecutive cycles produces back-to-back dn_wr pulses with no stall.
- An ioctl_wr in the same cycle as the ioctl_download falling edge is still accepted and written.
- byte_count saturates at 2^17-1.
- Async reset mid-download: returns to IDLE, so core_hold=1 and the core stays held. A ROM download must complete before RUN is reachable.

Decomposition:
- Shared package dl_pkg holds:
  - Index constants IDX_ROM=0, IDX_MOD=1, IDX_DIP=254.
  - Mod enum MOD_BWIDOW..MOD_SPACDUEL.
  - State enum {IDLE, LOAD_ROM, HOLD, RUN}.
- Sub-module hold_timer: a loadable down-counter with a done flag, used by the HOLD state.

Test Plan:
- ROM load: reset, then index-0 download of 65536 bytes where data = addr[7:0]. Required: 65536 dn_wr pulses, each 1 cycle after its ioctl_wr with matching addr/data; byte_count=65536; core_hold falls exactly 1024 cycles after the download falling edge; rom_loaded=1, rom_err=0.
- Short load: index-0 download of 100 bytes. Required: rom_err=1 and rom_loaded=0 after HOLD; core_hold falls after 1024 cycles.
- Overrun: a write at ioctl_addr=0x10000 during a ROM load. Required: no dn_wr for that byte; rom_err=1.
- Mod and DIPs: index 1 with byte 0x02 at addr 0; index 254 with bytes 0xA5 at addr 0 and 0x3C at addr 1, plus 0xFF at addr 9. Required: mod=2; dips[7:0]=0xA5, dips[15:8]=0x3C; other DIP bytes unchanged; core_hold unaffected while in RUN.
- Reload from RUN: in RUN, start an index-0 download. Required: core_hold=1 next cycle; rom_loaded=0; byte_count=0.
- Async reset mid-load: assert reset after 500 bytes. Required: all outputs return to reset values immediately; state IDLE; no dn_wr afterwards until a new download starts.
